// File: rtl/fb_pkg.sv
// Shared constants, scan-state encoding and address helper for the frame store.
package fb_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int FB_DEPTH     = SCREEN_W_DEF * SCREEN_H_DEF;
  localparam int FB_AW        = 15;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    OUT,
    DONE
  } scan_state_t;

  // Raster address for the default 160-pixel row: y*160 + x as two shifts and adds.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return (FB_AW'(y) << 7) + (FB_AW'(y) << 5) + FB_AW'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port frame store, 3 bits per pixel, one-cycle registered read data.
module fb_ram
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = FB_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [2:0]    wdata,
  output logic [2:0]    rdata
);

  localparam int IW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [IW-1:0] idx;

  assign idx = addr[IW-1:0];

  // Write on we, capture read data on re; rdata holds between reads.
  // NOTE: no reset here -- the array and its read register must stay reset-free to map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/framebuffer_scan.sv
// Pixel-plot sink with an on-chip frame store and a valid/ready raster readback.
module framebuffer_scan
  import fb_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  input  logic       scan_start,
  output logic       scan_busy,
  output logic       scan_done,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [2:0] pix_colour,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       plot_oob
);

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  scan_state_t      state;
  logic [7:0]       sx;
  logic [6:0]       sy;
  logic             plot_ok;
  logic             rd_en;
  logic [FB_AW-1:0] ram_addr;
  logic [2:0]       ram_rdata;

  // Shift-add address for the default width, generic multiply otherwise.
  function automatic logic [FB_AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    if (SCREEN_W == SCREEN_W_DEF) return fb_addr(x, y);
    return FB_AW'(int'(y) * SCREEN_W + int'(x));
  endfunction

  // Port arbitration: an in-range plot writes; a READ with no plot pending reads.
  // NOTE: every output of this block is assigned on every pass, so no latch can be inferred.
  always_comb begin
    plot_ok  = vga_plot && (vga_x <= X_LAST) && (vga_y <= Y_LAST);
    rd_en    = (state == READ) && !vga_plot;
    ram_addr = plot_ok ? pix_addr(vga_x, vga_y) : pix_addr(sx, sy);
  end

  fb_ram #(
    .DEPTH (SCREEN_W * SCREEN_H),
    .AW    (FB_AW)
  ) u_ram (
    .clk   (clk),
    .we    (plot_ok),
    .re    (rd_en),
    .addr  (ram_addr),
    .wdata (vga_colour),
    .rdata (ram_rdata)
  );

  // Sticky flag for any plot aimed outside the screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) plot_oob <= 1'b0;
    else if (vga_plot && !plot_ok) plot_oob <= 1'b1;
  end

  // Scan FSM with registered status outputs; counters only move on a pixel handshake.
  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sx        <= '0;
      sy        <= '0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_start) begin
            sx        <= '0;
            sy        <= '0;
            scan_busy <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (!vga_plot) begin
            pix_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (sx == X_LAST && sy == Y_LAST) begin
              scan_busy <= 1'b0;
              scan_done <= 1'b1;
              state     <= DONE;
            end else begin
              if (sx == X_LAST) begin
                sx <= '0;
                sy <= sy + 7'd1;
              end else begin
                sx <= sx + 8'd1;
              end
              state <= READ;
            end
          end
        end
        DONE: begin
          if (!scan_start) begin
            scan_done <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pix_x = sx;
  assign pix_y = sy;
  // Read data is not reset, so it is only exposed while a pixel is being offered.
  assign pix_colour = pix_valid ? ram_rdata : 3'd0;

endmodule

// File: tb/tb_framebuffer_scan.sv
// Scoreboard bench: each scan pushes the expected raster from a shadow frame and
// pops one entry per pixel handshake. A small 160-wide frame keeps runs short.
module tb_framebuffer_scan;

  localparam int W      = 160;
  localparam int H      = 12;
  localparam int NPIX   = W * H;
  localparam int BUDGET = 8 * NPIX + 64;

  localparam int S_READ = 1;
  localparam int S_OUT  = 2;
  localparam int S_DONE = 3;

  localparam int M_PLAIN = 0;
  localparam int M_BP    = 1;
  localparam int M_COLL  = 2;
  localparam int M_RST   = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       scan_start;
  logic       scan_busy;
  logic       scan_done;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_valid;
  logic       pix_ready;
  logic       plot_oob;

  logic [2:0] shadow [NPIX];
  pix_t       sb [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  framebuffer_scan #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .plot_oob   (plot_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic plot(input int x, input int y, input logic [2:0] c);
    @(negedge clk);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = c;
    vga_plot   = 1'b1;
    if (x < W && y < H) shadow[y * W + x] = c;
  endtask

  task automatic plot_end();
    @(negedge clk);
    vga_plot = 1'b0;
  endtask

  // Cycle 1 is the one in which scan_start is first sampled; the model state
  // tracks what the scan must look like in each following cycle.
  task automatic run_scan(input int mode, input int rst_at);
    int         st, cyc, stalls, waits, pops, done_cyc;
    logic       stalled, plot_now, rdy;
    bit         have_last;
    pix_t       held, e, got;
    logic [7:0] lx, px;
    logic [6:0] ly, py;
    sb.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back({8'(x), 7'(y), shadow[y * W + x]});
    @(negedge clk);
    vga_plot   = 1'b0;
    pix_ready  = 1'b0;
    scan_start = 1'b1;
    cyc = 1; st = S_READ; stalls = 0; waits = 0; pops = 0; done_cyc = 0;
    stalled = 1'b0; have_last = 1'b0; held = '0; lx = '0; ly = '0;
    while (st != S_DONE && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      got = {pix_x, pix_y, pix_colour};
      if (scan_done && done_cyc == 0) done_cyc = cyc;
      check("flags", {29'd0, scan_busy, scan_done, pix_valid}, {29'd0, 1'b1, 1'b0, st == S_OUT});
      if (stalled) check("stall_hold", got, held);
      stalled  = 1'b0;
      plot_now = 1'b0;
      rdy      = 1'b1;
      px = '0; py = '0;
      if (mode == M_BP || mode == M_COLL) rdy = 1'($urandom_range(0, 1));
      if (mode == M_COLL && cyc[0]) begin
        if (st == S_OUT) begin
          px = sb[0].x; py = sb[0].y; plot_now = 1'b1;
        end else if (have_last) begin
          px = lx; py = ly; plot_now = 1'b1;
        end
      end
      if (plot_now) begin
        vga_x      = px;
        vga_y      = py;
        vga_colour = shadow[int'(py) * W + int'(px)] ^ 3'b101;
        shadow[int'(py) * W + int'(px)] = vga_colour;
      end
      vga_plot  = plot_now;
      pix_ready = rdy;
      if (st == S_READ) begin
        if (plot_now) stalls++;
        else st = S_OUT;
      end else begin
        if (rdy) begin
          e = sb.pop_front();
          check("pixel", got, e);
          pops++;
          lx = e.x; ly = e.y; have_last = 1'b1;
          st = (int'(e.x) == W - 1 && int'(e.y) == H - 1) ? S_DONE : S_READ;
        end else begin
          waits++;
          stalled = 1'b1;
          held    = got;
        end
      end
      if (mode == M_RST && pops == rst_at) break;
    end

    if (mode == M_RST) begin
      rst_n      = 1'b0;
      scan_start = 1'b0;
      vga_plot   = 1'b0;
      pix_ready  = 1'b0;
      #1;
      check("rst_mid_outs", {14'd0, pix_x, pix_y, pix_colour, pix_valid, scan_busy, scan_done, plot_oob}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_outs", {14'd0, pix_x, pix_y, pix_colour, pix_valid, scan_busy, scan_done, plot_oob}, 32'd0);
      sb.delete();
    end else begin
      check("scan_end", st, S_DONE);
      @(negedge clk);
      cyc++;
      if (scan_done && done_cyc == 0) done_cyc = cyc;
      vga_plot = 1'b0;
      check("done_flags", {29'd0, scan_busy, scan_done, pix_valid}, 32'b010);
      check("done_cycle", done_cyc, 2 + 2 * NPIX + stalls + waits);
      check("leftover", sb.size(), 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("done_hold", {29'd0, scan_busy, scan_done, pix_valid}, 32'b010);
      end
      scan_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("back_idle", {29'd0, scan_busy, scan_done, pix_valid}, 32'b000);
      pix_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    scan_start = 1'b0;
    pix_ready  = 1'b0;
    #12;
    check("reset_outs", {14'd0, pix_x, pix_y, pix_colour, pix_valid, scan_busy, scan_done, plot_oob}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame, column-major, colour = x % 8.
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        plot(x, y, 3'(x % 8));
    plot_end();
    check("oob_clear", plot_oob, 1'b0);
    run_scan(M_PLAIN, 0);

    // Frame corners.
    plot(0, 0, 3'd3);
    plot(W - 1, 0, 3'd5);
    plot(0, H - 1, 3'd6);
    plot(W - 1, H - 1, 3'd7);
    plot_end();
    run_scan(M_PLAIN, 0);

    // Random backpressure.
    run_scan(M_BP, 0);

    // Plots every other cycle during a scan, then a rescan of the new contents.
    run_scan(M_COLL, 0);
    run_scan(M_PLAIN, 0);

    // Out-of-range plots alias onto (0,6) and past the end; neither may land.
    plot(W, 5, 3'd1);
    plot(3, H, 3'd2);
    plot_end();
    check("oob_set", plot_oob, 1'b1);
    run_scan(M_PLAIN, 0);
    check("oob_sticky", plot_oob, 1'b1);

    // Reset part-way through, then confirm the store survived.
    run_scan(M_RST, 500);
    run_scan(M_PLAIN, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
